// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), D first.
// Define MEM_ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT D grants with I waiting.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t state_r;
   logic   qi_s;
   logic   qd_s;
   logic   arb_s;
   logic   force_i_s;
   logic   pick_d_s;
   logic   pick_i_s;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
   end

   // Qualified requests and arbitration decision; a req seen alongside its gnt is already taken.
   always_comb begin
      qi_s     = i_req & ~i_gnt;
      qd_s     = d_req & ~d_gnt;
      arb_s    = (state_r == IDLE) | mem_ready;
      pick_d_s = qd_s & ~force_i_s;
      pick_i_s = qi_s & ~pick_d_s;
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt_r;

   assign force_i_s = qi_s & (starve_cnt_r == LIMIT);

   // Counts D grants made while I waits; saturates at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (arb_s) begin
         if (!qi_s || pick_i_s) begin
            starve_cnt_r <= 4'd0;
         end else if (pick_d_s && (starve_cnt_r != LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   assign force_i_s = 1'b0;
`endif

   // Transaction FSM: completes the current access and re-arbitrates on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         busy      <= 1'b0;
         i_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         i_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (state_r)
            BUSY_I: begin
               if (mem_ready) begin
                  i_rvalid <= 1'b1;
                  i_rdata  <= mem_rdata;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  d_rvalid <= 1'b1;
                  if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
            end
         endcase
         if (arb_s) begin
            if (pick_d_s) begin
               mem_addr  <= d_addr;
               mem_we    <= d_we;
               mem_wdata <= d_wdata;
               mem_req   <= 1'b1;
               d_gnt     <= 1'b1;
               busy      <= 1'b1;
               state_r   <= BUSY_D;
            end else if (pick_i_s) begin
               mem_addr  <= i_addr;
               mem_we    <= 1'b0;
               mem_req   <= 1'b1;
               i_gnt     <= 1'b1;
               busy      <= 1'b1;
               state_r   <= BUSY_I;
            end else begin
               mem_req   <= 1'b0;
               mem_we    <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected gnt/rvalid events, a monitor checks them.
module tb_mem_port_arbiter;

   localparam int K_IGNT = 0;
   localparam int K_DGNT = 1;
   localparam int K_IRV  = 2;
   localparam int K_DRV  = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } exp_t;

   logic        clock, reset;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ready, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] addr, input logic we, input logic [31:0] data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.we   = we;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   // Pops one expected event for an observed pulse and compares it.
   task automatic observe(input int kind);
      exp_t e;
      n_tests++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
         e = q.pop_front();
         if (e.kind != kind) begin
            n_fail++;
            $display("FAIL event_order: got kind %0d expected kind %0d", kind, e.kind);
         end else if (kind == K_IGNT || kind == K_DGNT) begin
            if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.data)) begin
               n_fail++;
               $display("FAIL gnt_fields: got addr %h we %b wdata %h expected addr %h we %b wdata %h",
                        mem_addr, mem_we, mem_wdata, e.addr, e.we, e.data);
            end
         end else begin
            if (((kind == K_IRV) ? i_rdata : d_rdata) !== e.data) begin
               n_fail++;
               $display("FAIL rdata: got %h expected %h", (kind == K_IRV) ? i_rdata : d_rdata, e.data);
            end
         end
      end
   endtask

   // Monitor: completions before grants within one cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (i_rvalid) observe(K_IRV);
         if (d_rvalid) observe(K_DRV);
         if (i_gnt)    observe(K_IGNT);
         if (d_gnt)    observe(K_DGNT);
      end
   end

   initial begin
      int n_starve;
      int d_last;
      int e_last;
      reset = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_pulses", {28'd0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      reset = 1'b0;
      step();

      // Single fetch, memory always ready
      i_req = 1'b1; i_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h2002_0004;
      push(K_IGNT, 32'h10, 1'b0, 32'h0);
      push(K_IRV, 32'h0, 1'b0, 32'h2002_0004);
      step();
      i_req = 1'b0;
      check("fetch_busy", {31'd0, busy}, 32'd1);
      check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
      step();
      check("fetch_i_rdata", i_rdata, 32'h2002_0004);
      check("fetch_idle", {31'd0, busy}, 32'd0);
      step();

      // Simultaneous I and D: D first, I chained with no idle cycle
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_rdata = 32'h1111_1111;
      push(K_DGNT, 32'h80, 1'b0, 32'h0);
      push(K_DRV, 32'h0, 1'b0, 32'h1111_1111);
      push(K_IGNT, 32'h20, 1'b0, 32'h0);
      push(K_IRV, 32'h0, 1'b0, 32'h2222_2222);
      step();
      d_req = 1'b0;
      check("sim_d_gnt", {30'd0, d_gnt, i_gnt}, 32'd2);
      step();
      i_req = 1'b0; mem_rdata = 32'h2222_2222;
      check("sim_i_gnt", {30'd0, d_gnt, i_gnt}, 32'd1);
      check("sim_mem_req", {31'd0, mem_req}, 32'd1);
      check("sim_busy", {31'd0, busy}, 32'd1);
      step();
      check("sim_i_rdata", i_rdata, 32'h2222_2222);
      step();

      // Write with three wait cycles
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      mem_ready = 1'b0; mem_rdata = 32'h3333_3333;
      push(K_DGNT, 32'h40, 1'b1, 32'hDEAD_BEEF);
      push(K_DRV, 32'h0, 1'b0, 32'h1111_1111);
      step();
      d_req = 1'b0; d_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("wr_req_we", {30'd0, mem_req, mem_we}, 32'd3);
         if (k == 3) mem_ready = 1'b1;
         step();
      end
      check("wr_done_req", {31'd0, mem_req}, 32'd0);
      check("wr_d_rdata_kept", d_rdata, 32'h1111_1111);
      mem_ready = 1'b0;
      step();

      // Starvation: D always pending, one wait cycle per access
`ifdef MEM_ARB_STARVE_GUARD_EN
      n_starve = 4;
      d_last   = 1000;
`else
      n_starve = 20;
      d_last   = 38;
`endif
      e_last = 2 * n_starve + 2;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      push(K_DGNT, 32'h200, 1'b0, 32'h0);
      for (int k = 1; k < n_starve; k++) begin
         push(K_DRV, 32'h0, 1'b0, 32'h4444_0000 | 32'(2 * k));
         push(K_DGNT, 32'h200, 1'b0, 32'h0);
      end
      push(K_DRV, 32'h0, 1'b0, 32'h4444_0000 | 32'(2 * n_starve));
      push(K_IGNT, 32'h100, 1'b0, 32'h0);
      push(K_IRV, 32'h0, 1'b0, 32'h4444_0000 | 32'(e_last));
      for (int e = 0; e <= e_last; e++) begin
         mem_ready = (e > 0) && (e % 2 == 0);
         mem_rdata = 32'h4444_0000 | 32'(e);
         step();
         if (e <= 2 * n_starve + 1) check("starve_mem_req", {31'd0, mem_req}, 32'd1);
         if (e == d_last) d_req = 1'b0;
         if (i_gnt) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
      end
      check("starve_idle", {31'd0, busy}, 32'd0);
      mem_ready = 1'b0;
      step();

      // Reset while a D read waits on memory
      d_req = 1'b1; d_addr = 32'h300; mem_ready = 1'b0;
      push(K_DGNT, 32'h300, 1'b0, 32'h0);
      step();
      d_req = 1'b0;
      step();
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_outs", {29'd0, mem_req, busy, d_rvalid}, 32'd0);
      #3 reset = 1'b0;
      mem_ready = 1'b1;
      step();
      check("post_rst_no_rvalid", {29'd0, d_rvalid, i_rvalid, busy}, 32'd0);
      mem_ready = 1'b0;
      step();
      check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
